// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating mux: mode encodings,
// output-stage state type and the channel-index width helper.
package rr_arb_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational grant selection. Round-robin searches upward from ptr with
// wrap-around; fixed priority always picks the lowest requesting index.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = MODE_RR,
    parameter int CW   = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [N_CH-1:0] gnt,
    output logic [CW-1:0]   idx
);

    // First pass covers channels at or above the pointer, second pass wraps to
    // the bottom; in fixed mode the first pass already spans every channel.
    always_comb begin
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            if (!found && req[j] && (MODE == MODE_FIXED || j >= int'(ptr))) begin
                gnt[j] = 1'b1;
                idx    = CW'(j);
                found  = 1'b1;
            end
        end
        for (int j = 0; j < N_CH; j++) begin
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                idx    = CW'(j);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready arbitrating mux with a single registered output slice.
// A word is captured on the edge it is granted, so latency is one cycle and
// a full slice can be drained and refilled in the same cycle.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int W      = 8,
    parameter int MODE   = MODE_RR,
    parameter int INVERT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic [N_CH*W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [cw_of(N_CH)-1:0]   out_ch
);

    localparam int CW = cw_of(N_CH);

    ostate_t          state;
    logic [CW-1:0]    rr_ptr;
    logic [N_CH-1:0]  gnt_p0;
    logic [CW-1:0]    idx_p0;
    logic [W-1:0]     sel_p0;
    logic             load_ok;
    logic             accept;

    // ---- stage 0: arbitration and input select (combinational) ----
    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE),
        .CW   (CW)
    ) u_arb (
        .req  (in_valid),
        .ptr  (rr_ptr),
        .gnt  (gnt_p0),
        .idx  (idx_p0)
    );

    assign out_valid = (state == ST_FULL);
    assign load_ok   = (state == ST_EMPTY) || (out_ready && out_valid);
    // rst_n gates ready so nothing is handshaken while reset is held.
    assign in_ready  = (rst_n && load_ok) ? gnt_p0 : '0;
    assign accept    = |in_ready;

    // Mux the granted channel's word onto the capture bus.
    always_comb begin
        sel_p0 = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_p0[k]) sel_p0 = in_data[k*W +: W];
        end
    end

    // ---- stage 1: output register slice and arbitration pointer ----
    // Capture on accept, otherwise drain to EMPTY when downstream takes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
        end else if (accept) begin
            state    <= ST_FULL;
            out_data <= (INVERT != 0) ? ~sel_p0 : sel_p0;
            out_ch   <= idx_p0;
        end else if (out_ready) begin
            state    <= ST_EMPTY;
        end
    end

    // Pointer moves just past the winner, only on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && MODE == MODE_RR) begin
            rr_ptr <= (int'(idx_p0) == N_CH - 1) ? '0 : idx_p0 + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (round-robin, fixed priority,
// round-robin with inverted data) share stimulus and are compared every
// cycle against a queue-free behavioural model, plus directed literal checks.
module tb_rr_arb_mux;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic [3:0]  ir  [NI];
    logic        ov  [NI];
    logic [7:0]  od  [NI];
    logic [1:0]  och [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.N_CH(4), .W(8), .MODE(0), .INVERT(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_ch(och[0]));

    rr_arb_mux #(.N_CH(4), .W(8), .MODE(1), .INVERT(0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_ch(och[1]));

    rr_arb_mux #(.N_CH(4), .W(8), .MODE(0), .INVERT(1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_ch(och[2]));

    // ---------------- behavioural model ----------------
    int         m_mode [NI] = '{0, 1, 0};
    int         m_inv  [NI] = '{0, 0, 1};
    int         m_full [NI] = '{0, 0, 0};
    int         m_ch   [NI] = '{0, 0, 0};
    int         m_ptr  [NI] = '{0, 0, 0};
    logic [7:0] m_data [NI] = '{8'h0, 8'h0, 8'h0};

    // Winner among valid channels: rotate from the pointer, or lowest index.
    function automatic int grant_of(input int inst, input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_mode[inst] == 1) ? i : (m_ptr[inst] + i) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int inst);
        int g;
        if (rst_n !== 1'b1) return 4'b0;
        if (!(m_full[inst] == 0 || out_ready)) return 4'b0;
        g = grant_of(inst, in_valid);
        if (g < 0) return 4'b0;
        return 4'(1 << g);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst_n !== 1'b1) begin
                m_full[k] = 0; m_ch[k] = 0; m_ptr[k] = 0; m_data[k] = 8'h0;
            end else if (exp_ready(k) != 4'b0) begin
                int g;
                logic [7:0] w;
                g = grant_of(k, in_valid);
                w = in_data[g*8 +: 8];
                m_full[k] = 1;
                m_data[k] = (m_inv[k] != 0) ? ~w : w;
                m_ch[k]   = g;
                if (m_mode[k] == 0) m_ptr[k] = (g + 1) % 4;
            end else if (out_ready) begin
                m_full[k] = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs of all instances.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            logic rs;
            rs = (rst_n === 1'b1);
            chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(exp_ready(k)));
            chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), rs ? 32'(m_full[k]) : 32'd0);
            if (!rs || m_full[k] != 0) begin
                chk($sformatf("out_data[%0d]", k), 32'(od[k]), rs ? 32'(m_data[k]) : 32'd0);
                chk($sformatf("out_ch[%0d]", k), 32'(och[k]), rs ? 32'(m_ch[k]) : 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        repeat (2) step();
        for (int k = 0; k < NI; k++) begin
            chk("reset out_valid", 32'(ov[k]), 32'd0);
            chk("reset out_data", 32'(od[k]), 32'd0);
            chk("reset out_ch", 32'(och[k]), 32'd0);
        end
        rst_n = 1'b1;

        // Round-robin fairness and fixed-priority behaviour, all channels valid.
        in_valid  = 4'hF;
        in_data   = $urandom;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr sequence out_ch", 32'(och[0]), 32'(i % 4));
            chk("fixed out_ch", 32'(och[1]), 32'd0);
            chk("fixed in_ready", 32'(ir[1]), 32'h1);
        end

        // Asynchronous reset while full: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(ov[0]), 32'd0);
        chk("async rst out_data", 32'(od[0]), 32'd0);
        chk("async rst out_ch", 32'(och[0]), 32'd0);
        chk("async rst in_ready", 32'(ir[0]), 32'd0);
        step();
        rst_n = 1'b1;

        // Backpressure: hold A5 from channel 2 for five cycles.
        in_valid  = 4'b0100;
        in_data   = 32'h00A5_0000;
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = 4'($urandom);
            in_data  = $urandom;
            step();
            chk("hold out_valid", 32'(ov[0]), 32'd1);
            chk("hold out_data", 32'(od[0]), 32'hA5);
            chk("hold out_ch", 32'(och[0]), 32'd2);
            chk("hold in_ready", 32'(ir[0]), 32'd0);
        end
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        chk("ptr after hold", 32'(ir[0]), 32'h8);

        // Inverted data path.
        do_reset();
        in_valid = 4'b0010;
        in_data  = 32'h0000_3C00;
        out_ready = 1'b1;
        #1;
        chk("invert pre out_valid", 32'(ov[2]), 32'd0);
        step();
        chk("invert out_data", 32'(od[2]), 32'hC3);
        chk("invert out_ch", 32'(och[2]), 32'd1);
        chk("invert out_valid", 32'(ov[2]), 32'd1);

        // Sparse request: pointer wraps to 0 after channel 3 wins.
        do_reset();
        in_valid = 4'b1000;
        step();
        chk("sparse out_ch 3", 32'(och[0]), 32'd3);
        in_valid = 4'b0101;
        #1;
        chk("sparse in_ready", 32'(ir[0]), 32'h1);
        step();
        chk("sparse out_ch 0", 32'(och[0]), 32'd0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            in_valid  = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
